// File: rtl/mux_feed_ctrl.sv
// Operand bank and select sequencer feeding the 8-to-1 byte mux.
// Loads eight bytes, then scans Sel through all slots with a fixed dwell.
module mux_feed_ctrl #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    input  logic       start,
    input  logic       stop,
    input  logic       reload,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [7:0] C,
    output logic [7:0] D,
    output logic [7:0] E,
    output logic [7:0] F,
    output logic [7:0] G,
    output logic [7:0] H,
    output logic [2:0] Sel,
    output logic [2:0] slot,
    output logic       out_valid,
    output logic       done
);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_READY = 2'd1,
        S_SCAN  = 2'd2
    } state_e;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_e     state_q, state_d;
    logic [2:0] wptr_q, wptr_d;
    logic [7:0] ops_q [8];
    logic [7:0] ops_d [8];
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] slot_q, slot_d;
    logic [2:0] sel_q, sel_d;
    logic       out_valid_q, out_valid_d;
    logic       done_q, done_d;

    logic wr_fire;
    logic dwell_end;
    logic scan_end;
    logic go;
    logic back;

    assign wr_fire   = (state_q == S_LOAD) && wr_valid;
    assign dwell_end = (cnt_q == LAST);
    assign scan_end  = dwell_end && (slot_q == 3'd7);
    assign go        = (state_q == S_READY) && start;
    assign back      = (state_q == S_READY) && !start && reload;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: begin
                if (wr_fire && (wptr_q == 3'd7)) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (start) begin
                    state_d = S_SCAN;
                end else if (reload) begin
                    state_d = S_LOAD;
                end
            end
            S_SCAN: begin
                if (stop || scan_end) begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Datapath next values: bank, write pointer, dwell counter, slot
    always_comb begin
        wptr_d = wptr_q;
        ops_d  = ops_q;
        cnt_d  = cnt_q;
        slot_d = slot_q;

        if (wr_fire) begin
            ops_d[wptr_q] = wr_data;
            wptr_d        = wptr_q + 3'd1;
        end

        if (back) begin
            wptr_d = 3'd0;
        end

        if (go) begin
            cnt_d  = 8'd0;
            slot_d = 3'd0;
        end else if ((state_q == S_SCAN) && !stop) begin
            if (dwell_end) begin
                cnt_d = 8'd0;
                // Slot 7 is kept after completion so Sel holds its last value
                if (!scan_end) begin
                    slot_d = slot_q + 3'd1;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Registered output values
    always_comb begin
        out_valid_d = (state_d == S_SCAN);
        done_d      = (state_q == S_SCAN) && !stop && scan_end;
        sel_d       = {slot_d[0], slot_d[1], slot_d[2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= 3'd0;
            cnt_q       <= 8'd0;
            slot_q      <= 3'd0;
            sel_q       <= 3'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ops_q[i] <= 8'd0;
            end
        end else begin
            wptr_q      <= wptr_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            for (int i = 0; i < 8; i++) begin
                ops_q[i] <= ops_d[i];
            end
        end
    end

    assign wr_ready  = (state_q == S_LOAD);
    assign A         = ops_q[0];
    assign B         = ops_q[1];
    assign C         = ops_q[2];
    assign D         = ops_q[3];
    assign E         = ops_q[4];
    assign F         = ops_q[5];
    assign G         = ops_q[6];
    assign H         = ops_q[7];
    assign Sel       = sel_q;
    assign slot      = slot_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mux_feed_ctrl.sv
// Bench for mux_feed_ctrl: scenario tasks checked against a
// reference model of the operand bank and scan timeline.
module tb_mux_feed_ctrl;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic       stop;
    logic       reload;
    logic [7:0] A, B, C, D, E, F, G, H;
    logic [2:0] Sel;
    logic [2:0] slot;
    logic       out_valid;
    logic       done;

    logic [7:0] outs [8];
    logic [7:0] ops_m [8];
    logic [7:0] new_v [8];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign outs = '{A, B, C, D, E, F, G, H};

    mux_feed_ctrl #(.DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .start(start), .stop(stop), .reload(reload),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
        .Sel(Sel), .slot(slot), .out_valid(out_valid), .done(done)
    );

    function automatic logic [2:0] rev3(input int s);
        return 3'(((s & 1) << 2) | (s & 2) | ((s >> 2) & 1));
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write new_v[first..7]; gap: 0 none, 1 alternate idle, 2 random idle
    task automatic load_seq(input int first, input int gap);
        for (int i = first; i < 8; i++) begin
            int idle;
            idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < idle; j++) begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
                start    = 1'($urandom);
                stop     = 1'($urandom);
                reload   = 1'($urandom);
                tick();
                start = 1'b0; stop = 1'b0; reload = 1'b0;
                n_chk++;
                if (wr_ready !== 1'b1 || out_valid !== 1'b0)
                    $display("FAIL load_idle: rdy=%b ov=%b want 1 0", wr_ready, out_valid);
                else n_pass++;
                n_chk++;
                if (outs[i] !== ops_m[i])
                    $display("FAIL idle_hold%0d: got %h want %h", i, outs[i], ops_m[i]);
                else n_pass++;
            end
            wr_valid = 1'b1;
            wr_data  = new_v[i];
            tick();
            wr_valid = 1'b0;
            ops_m[i] = new_v[i];
            for (int k = 0; k < 8; k++) begin
                n_chk++;
                if (outs[k] !== ops_m[k])
                    $display("FAIL write%0d_op%0d: got %h want %h", i, k, outs[k], ops_m[k]);
                else n_pass++;
            end
            n_chk++;
            if (wr_ready !== (i < 7))
                $display("FAIL wr_ready_w%0d: got %b want %b", i, wr_ready, i < 7);
            else n_pass++;
        end
    endtask

    // Starts in SCAN cycle 0; returns in the done cycle, or just after stop
    task automatic run_scan(input int stop_k);
        for (int k = 0; k < 8 * DW; k++) begin
            int s;
            s = k / DW;
            n_chk++;
            if (out_valid !== 1'b1 || done !== 1'b0)
                $display("FAIL scan_ov_c%0d: ov=%b done=%b want 1 0", k, out_valid, done);
            else n_pass++;
            n_chk++;
            if (slot !== 3'(s) || Sel !== rev3(s))
                $display("FAIL scan_sel_c%0d: slot=%0d Sel=%b want %0d %b", k, slot, Sel, s, rev3(s));
            else n_pass++;
            if (k == stop_k) begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                n_chk++;
                if (out_valid !== 1'b0 || done !== 1'b0)
                    $display("FAIL stop_out: ov=%b done=%b want 0 0", out_valid, done);
                else n_pass++;
                n_chk++;
                if (slot !== 3'(s) || Sel !== rev3(s))
                    $display("FAIL stop_hold: slot=%0d Sel=%b want %0d %b", slot, Sel, s, rev3(s));
                else n_pass++;
                return;
            end
            wr_valid = 1'($urandom);
            wr_data  = 8'($urandom);
            tick();
            wr_valid = 1'b0;
        end
        n_chk++;
        if (done !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL scan_done: done=%b ov=%b want 1 0", done, out_valid);
        else n_pass++;
        n_chk++;
        if (slot !== 3'd7 || Sel !== 3'b111 || wr_ready !== 1'b0)
            $display("FAIL end_hold: slot=%0d Sel=%b rdy=%b want 7 111 0", slot, Sel, wr_ready);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (outs[i] !== ops_m[i])
                $display("FAIL scan_ops%0d: got %h want %h", i, outs[i], ops_m[i]);
            else n_pass++;
        end
    endtask

    task automatic do_reload;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        n_chk++;
        if (wr_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reload: rdy=%b ov=%b want 1 0", wr_ready, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_data = 8'h00;
        start = 1'b0; stop = 1'b0; reload = 1'b0;
        #12;
        for (int i = 0; i < 8; i++) ops_m[i] = 8'h00;
        n_chk++;
        if (wr_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_ctl: rdy=%b ov=%b done=%b want 1 0 0", wr_ready, out_valid, done);
        else n_pass++;
        n_chk++;
        if (Sel !== 3'd0 || slot !== 3'd0)
            $display("FAIL reset_sel: Sel=%b slot=%0d want 0 0", Sel, slot);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (outs[i] !== 8'h00)
                $display("FAIL reset_op%0d: got %h want 00", i, outs[i]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load;
        for (int i = 0; i < 8; i++) new_v[i] = 8'((i + 1) * 8'h11);
        load_seq(0, 0);
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        tick();
        wr_valid = 1'b0;
        n_chk++;
        if (A !== 8'h11 || H !== 8'h88 || wr_ready !== 1'b0)
            $display("FAIL ninth_write: A=%h H=%h rdy=%b want 11 88 0", A, H, wr_ready);
        else n_pass++;
    endtask

    task automatic test_scan;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_scan(-1);
        tick();
        n_chk++;
        if (done !== 1'b0 || out_valid !== 1'b0 || slot !== 3'd7)
            $display("FAIL after_done: done=%b ov=%b slot=%0d want 0 0 7", done, out_valid, slot);
        else n_pass++;
    endtask

    task automatic test_stop;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_scan(3 * DW + 2);
        n_chk++;
        if (Sel !== 3'b110)
            $display("FAIL stop_sel: got %b want 110", Sel);
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            tick();
            n_chk++;
            if (done !== 1'b0 || out_valid !== 1'b0 || Sel !== 3'b110)
                $display("FAIL stop_quiet: done=%b ov=%b Sel=%b want 0 0 110", done, out_valid, Sel);
            else n_pass++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        run_scan(-1);
        tick();
    endtask

    task automatic test_back_to_back;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_scan(-1);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_chk++;
        if (done !== 1'b0 || out_valid !== 1'b1 || slot !== 3'd0)
            $display("FAIL b2b_start: done=%b ov=%b slot=%0d want 0 1 0", done, out_valid, slot);
        else n_pass++;
        run_scan(-1);
        tick();
    endtask

    task automatic test_gapped;
        do_reload();
        for (int i = 0; i < 8; i++) new_v[i] = 8'(8'hA0 + i);
        load_seq(0, 1);
    endtask

    task automatic test_start_reload;
        start = 1'b1; reload = 1'b1;
        tick();
        start = 1'b0; reload = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || wr_ready !== 1'b0 || slot !== 3'd0)
            $display("FAIL start_wins: ov=%b rdy=%b slot=%0d want 1 0 0", out_valid, wr_ready, slot);
        else n_pass++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        do_reload();
        new_v[0] = 8'hFF;
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        tick();
        wr_valid = 1'b0;
        ops_m[0] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (outs[i] !== ops_m[i])
                $display("FAIL reload_op%0d: got %h want %h", i, outs[i], ops_m[i]);
            else n_pass++;
        end
        for (int i = 1; i < 8; i++) new_v[i] = 8'($urandom);
        load_seq(1, 0);
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            do_reload();
            for (int i = 0; i < 8; i++) new_v[i] = 8'($urandom);
            load_seq(0, 2);
            start = 1'b1;
            reload = 1'($urandom);
            tick();
            start = 1'b0; reload = 1'b0;
            run_scan(int'($urandom_range(0, 8 * DW)));
            tick();
        end
    endtask

    task automatic test_async_reset;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 5 * DW + 1; j++) tick();
        n_chk++;
        if (slot !== 3'd5 || out_valid !== 1'b1)
            $display("FAIL pre_rst: slot=%0d ov=%b want 5 1", slot, out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) ops_m[i] = 8'h00;
        n_chk++;
        if (out_valid !== 1'b0 || done !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL async_ctl: ov=%b done=%b rdy=%b want 0 0 1", out_valid, done, wr_ready);
        else n_pass++;
        n_chk++;
        if (Sel !== 3'd0 || slot !== 3'd0)
            $display("FAIL async_sel: Sel=%b slot=%0d want 0 0", Sel, slot);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (outs[i] !== 8'h00)
                $display("FAIL async_op%0d: got %h want 00", i, outs[i]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (done !== 1'b0 || wr_ready !== 1'b1)
            $display("FAIL post_rst: done=%b rdy=%b want 0 1", done, wr_ready);
        else n_pass++;
        new_v[0] = 8'h5A;
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        tick();
        wr_valid = 1'b0;
        n_chk++;
        if (A !== 8'h5A || B !== 8'h00)
            $display("FAIL post_rst_wr: A=%h B=%h want 5a 00", A, B);
        else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_scan();
        test_stop();
        test_back_to_back();
        test_gapped();
        test_start_reload();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mux_feed_ctrl.md
# mux_feed_ctrl

Register bank and select sequencer that sits directly upstream of the 8-to-1 byte multiplexer. It loads eight 8-bit operands through a valid/ready write port and presents them on outputs A–H. On command it steps the multiplexer select through all eight slots, holding each slot for a programmable dwell, then returns to an idle-ready state with its contents retained.

## Interface
- DWELL, 4, cycles each slot is held during a scan; legal range 1–255
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- wr_valid  in  1  write request
- wr_data  in  8  operand to store
- wr_ready  out  1  bank accepting writes (high only in LOAD)
- start  in  1  begin scan (sampled in READY only)
- stop  in  1  abort scan (sampled in SCAN only)
- reload  in  1  return to LOAD and clear write pointer (sampled in READY only)
- A, B, C, D, E, F, G, H  out  8 each  stored operands 0..7, registered
- Sel  out  3  mux select, registered, bit-reversed slot index
- slot  out  3  current slot index, registered
- out_valid  out  1  high while SCAN presents a slot
- done  out  1  one-cycle pulse on scan completion

## Operation
- States: LOAD, READY, SCAN.
- Reset (asynchronous, rst_n low):
  - state = LOAD, write pointer = 0
  - A–H = 0, Sel = 0, slot = 0, dwell counter = 0
  - out_valid = 0, done = 0; wr_ready = 1 (follows LOAD)
- LOAD:
  - A write occurs on a rising edge with wr_valid & wr_ready. wr_data is stored into operand[wptr] (0→A … 7→H) and wptr increments.
  - The write that stores H (wptr = 7) moves the block to READY and wraps wptr to 0.
  - start, stop and reload are ignored.
- READY:
  - wr_ready = 0; wr_valid is ignored.
  - start moves to SCAN with slot = 0 and dwell counter = 0.
  - reload moves to LOAD with wptr = 0. Operand contents are unchanged until overwritten.
  - If start and reload are both high, start wins.
- SCAN:
  - out_valid = 1. The dwell counter counts 0..DWELL-1.
  - At DWELL-1 the counter clears and slot increments.
  - At slot 7 with DWELL-1, the block returns to READY, out_valid drops and done pulses for one cycle.
  - stop has priority over dwell advance: the block goes to READY on the next edge, out_valid = 0, no done pulse, slot and Sel hold their last values.
- Sel encoding: Sel = {slot[0], slot[1], slot[2]}. The downstream mux decodes bit 0 as MSB, so slot i selects operand i (slot 1 → Sel 3'b100 → B; slot 3 → 3'b110 → D).
- Sel and slot update on the same edge. Outside SCAN they keep their last value; a new start reloads both to 0.
- Operands change only on accepted writes, never during SCAN.

## Timing
- Write latency: operand output updates on the edge that accepts the write. wr_ready falls on the edge accepting the 8th write.
- start → SCAN: start high in READY at edge N gives out_valid = 1, slot = 0, Sel = 000 after edge N.
- Each slot is presented for exactly DWELL cycles. A full scan gives out_valid high for 8·DWELL consecutive cycles.
- done is high the cycle after the final dwell cycle. That cycle coincides with out_valid = 0 and state READY; start is accepted in that same cycle.
- stop at edge M ends SCAN at edge M; out_valid is low after M.
- rst_n asserted mid-LOAD or mid-SCAN clears everything immediately, with no done pulse. Release is synchronous to the next clk edge.
- DWELL = 1: slot advances every cycle and the scan lasts 8 cycles.

## Test plan
- Reset, then write 0x11,0x22,…,0x88 back-to-back → A=0x11 … H=0x88, wr_ready low one cycle after the 8th write, 9th wr_valid ignored.
- DWELL=4, start → Sel sequence 000,100,010,110,001,101,011,111, each held 4 cycles. out_valid high 32 cycles, done pulses once on cycle 33.
- Mid-scan stop at slot 3, cycle 2 → out_valid low next cycle, no done, Sel holds 110. Restart → slot 0.
- Gapped writes (wr_valid toggled every other cycle) with 0xA0..0xA7 → stored in order, wptr does not advance on idle cycles.
- READY with start and reload asserted together → SCAN entered. A separate reload → wr_ready high, new write of 0xFF lands in A, B–H keep their old values.
- rst_n pulsed low during SCAN slot 5 → all outputs 0 asynchronously, state LOAD, wr_ready = 1.
